hs_io_port: RTL
===============

HS_IO_PORT -- requirements
Module: hs_io_port

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set entries per FIFO (power of 2, min 2).
REQ-002 Parameter TIMEOUT, default 255, SHALL set the cycles a request may stall before error (used only with HS_IO_TIMEOUT_EN).
REQ-003 g_clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-004 g_clr  in  1  asynchronous, active-low reset.
REQ-005 proc_hs_out  in  1  processor request (processor hs_out).
REQ-006 proc_dir  in  1  1 = processor writes (bus_out to port); 0 = processor reads (port to bus_in).
REQ-007 proc_bus_out  in  8  processor write data.
REQ-008 proc_bus_in  out  8  read data to processor.
REQ-009 proc_hs_in  out  1  acknowledge to processor (processor hs_in).
REQ-010 host_tx_data/host_tx_valid  in  8/1  host byte pushed toward processor.
REQ-011 host_tx_ready  out  1  TX FIFO not full.
REQ-012 host_rx_data/host_rx_valid  out  8/1  byte received from processor, head of RX FIFO.
REQ-013 host_rx_ready  in  1  host pop of RX head.
REQ-014 tx_count, rx_count  out  clog2(DEPTH)+1 each  FIFO occupancy.
REQ-015 timeout_err  out  1  sticky stall-timeout flag.

Function
REQ-016 The block SHALL be the peripheral (responder) end of the processor four-phase hs_out/hs_in handshake.
REQ-017 FSM states SHALL be IDLE, XFER, ACK.
REQ-018 IDLE->XFER when proc_hs_out=1 and (proc_dir=1 and RX not full, or proc_dir=0 and TX not empty); otherwise remain in IDLE (stall, proc_hs_in=0).
REQ-019 In XFER: write direction SHALL push proc_bus_out into RX; read direction SHALL drive TX head on proc_bus_in. Next state is ACK unconditionally.
REQ-020 In ACK: proc_hs_in=1; on proc_hs_out=0, read direction SHALL pop TX, and the FSM goes to IDLE with proc_hs_in=0 the next cycle.
REQ-021 proc_hs_in SHALL rise exactly 2 cycles after the first cycle proc_hs_out=1 is sampled with the FIFO ready.
REQ-022 proc_dir SHALL be latched in IDLE->XFER and held for the transfer; later changes are ignored.
REQ-023 proc_bus_in SHALL remain stable from XFER until leaving ACK; it SHALL be 8'h00 in IDLE.
REQ-024 Host push SHALL occur when host_tx_valid & host_tx_ready; host pop when host_rx_valid & host_rx_ready.
REQ-025 A simultaneous push and pop on one FIFO SHALL leave its count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-026 Pushes into a full FIFO and pops from an empty FIFO SHALL never occur (gated internally).
REQ-027 host_rx_data SHALL show the RX head whenever host_rx_valid=1 (first-word fall-through).

Reset
REQ-028 g_clr=0 SHALL immediately force: IDLE, proc_hs_in=0, proc_bus_in=8'h00, both FIFOs empty, counts 0, host_tx_ready=1, host_rx_valid=0, timeout_err=0, timeout counter 0.
REQ-029 Reset during XFER/ACK SHALL abort the transfer with no push or pop committed beyond those already clocked.

Configuration
REQ-030 With HS_IO_TIMEOUT_EN defined: counter increments each IDLE cycle with proc_hs_out=1 and FIFO not ready; on reaching TIMEOUT it SHALL set timeout_err (sticky until reset); cleared to 0 on any IDLE->XFER.
REQ-031 Without HS_IO_TIMEOUT_EN: no counter logic; timeout_err tied 0.

Structure
REQ-032 Package hs_io_pkg SHALL hold the FSM state enum (IDLE/XFER/ACK), the byte width constant (8) and the default DEPTH/TIMEOUT constants.
REQ-033 Sub-module byte_fifo (parameter DEPTH, push/pop/data/count/full/empty) SHALL be instantiated twice (TX, RX).

Verification
REQ-034 Host pushes 8'hA5; processor read (dir=0, hs_out=1) -> proc_hs_in high 2 cycles later, proc_bus_in=8'hA5; after hs_out drops, tx_count=0.
REQ-035 Processor write 8'h3C (dir=1) -> rx_count=1, host_rx_valid=1, host_rx_data=8'h3C; host pop -> rx_count=0.
REQ-036 Read with TX empty -> proc_hs_in stays 0; host pushes 8'h11 -> ack 2 cycles after push lands, data 8'h11.
REQ-037 Four writes (DEPTH=4) then fifth -> fifth stalls until host pops, then completes; order preserved 1,2,3,4,5.
REQ-038 Macro on, TIMEOUT=10, read with TX empty for 12 cycles -> timeout_err=1 and sticky; macro off -> timeout_err=0.
REQ-039 g_clr low during ACK -> proc_hs_in=0 and counts 0 immediately; next handshake completes normally.

Source files
------------

// File: rtl/hs_io_pkg.sv
// rtl/hs_io_pkg.sv - shared types and constants for the hs_io_port handshake peripheral
package hs_io_pkg;

    localparam int BYTE_W          = 8;
    localparam int DEFAULT_DEPTH   = 4;
    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        ACK  = 2'd2
    } hs_state_t;

endpackage

// File: rtl/hs_io_port_if.sv
// rtl/hs_io_port_if.sv - processor-side four-phase hs_out/hs_in handshake bus
interface hs_io_port_if;
    import hs_io_pkg::*;

    logic              hs_out;
    logic              dir;
    logic [BYTE_W-1:0] bus_out;
    logic [BYTE_W-1:0] bus_in;
    logic              hs_in;

    modport master (output hs_out, dir, bus_out, input  bus_in, hs_in);
    modport slave  (input  hs_out, dir, bus_out, output bus_in, hs_in);

endinterface

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - first-word fall-through byte FIFO, power-of-two DEPTH
module byte_fifo
    import hs_io_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [BYTE_W-1:0]        wdata,
    output logic [BYTE_W-1:0]        rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Overflow and underflow are blocked here so callers never corrupt state
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/hs_io_port.sv
// rtl/hs_io_port.sv - four-phase responder bridging a processor to host TX/RX byte FIFOs; HS_IO_TIMEOUT_EN adds stall timeout
module hs_io_port
    import hs_io_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                   g_clk,
    input  logic                   g_clr,
    hs_io_port_if.slave            proc,
    input  logic [BYTE_W-1:0]      host_tx_data,
    input  logic                   host_tx_valid,
    output logic                   host_tx_ready,
    output logic [BYTE_W-1:0]      host_rx_data,
    output logic                   host_rx_valid,
    input  logic                   host_rx_ready,
    output logic [$clog2(DEPTH):0] tx_count,
    output logic [$clog2(DEPTH):0] rx_count,
    output logic                   timeout_err
);
    hs_state_t         state;
    logic              dir_q;
    logic              hs_in_q;
    logic [BYTE_W-1:0] bus_in_q;

    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [BYTE_W-1:0] tx_rdata;
    logic              tx_pop, rx_push;
    logic              fifo_ready;

    assign fifo_ready    = proc.dir ? !rx_full : !tx_empty;
    assign rx_push       = (state == XFER) && dir_q;
    assign tx_pop        = (state == ACK) && !proc.hs_out && !dir_q;

    assign host_tx_ready = !tx_full;
    assign host_rx_valid = !rx_empty;
    assign proc.hs_in    = hs_in_q;
    assign proc.bus_in   = bus_in_q;

    byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk   (g_clk),
        .rst_n (g_clr),
        .push  (host_tx_valid),
        .pop   (tx_pop),
        .wdata (host_tx_data),
        .rdata (tx_rdata),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk   (g_clk),
        .rst_n (g_clr),
        .push  (rx_push),
        .pop   (host_rx_ready),
        .wdata (proc.bus_out),
        .rdata (host_rx_data),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Read data is captured on entry to XFER; TX head cannot move until the pop leaving ACK
    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            state    <= IDLE;
            dir_q    <= 1'b0;
            hs_in_q  <= 1'b0;
            bus_in_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (proc.hs_out && fifo_ready) begin
                        state    <= XFER;
                        dir_q    <= proc.dir;
                        bus_in_q <= proc.dir ? '0 : tx_rdata;
                    end
                end
                XFER: begin
                    state   <= ACK;
                    hs_in_q <= 1'b1;
                end
                ACK: begin
                    if (!proc.hs_out) begin
                        state    <= IDLE;
                        hs_in_q  <= 1'b0;
                        bus_in_q <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef HS_IO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] stall_cnt;
    logic          err_q;

    assign timeout_err = err_q;

    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            stall_cnt <= '0;
            err_q     <= 1'b0;
        end else if (state == IDLE && proc.hs_out) begin
            if (fifo_ready) begin
                stall_cnt <= '0;
            end else if (stall_cnt != TW'(TIMEOUT)) begin
                stall_cnt <= stall_cnt + TW'(1);
                if (stall_cnt >= TW'(TIMEOUT - 1)) begin
                    err_q <= 1'b1;
                end
            end
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule
